// File: rtl/delay_arbiter.sv
// Four-client round-robin front end for a shared microsecond delay engine.
// The owner keeps the engine until its latched delay expires (done pulse) or it drops req (abort).
module delay_arbiter #(
    parameter int CLK_PER_US = 50,
    parameter int W          = 16
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [3:0]     req,
    input  logic [4*W-1:0] nus,
    output logic [3:0]     grant,
    output logic [3:0]     done,
    output logic [1:0]     cur_id,
    output logic           busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] PCNT_LAST = 16'(CLK_PER_US - 1);

    state_t         state, state_nx;
    logic [1:0]     ptr, ptr_nx;
    logic [15:0]    pcnt, pcnt_nx;
    logic [W-1:0]   ucnt, ucnt_nx;
    logic [W-1:0]   nlat, nlat_nx;
    logic [3:0]     grant_nx;
    logic [3:0]     done_nx;
    logic [1:0]     cur_id_nx;
    logic           busy_nx;
    logic [2:0]     pick;

    function automatic logic [3:0] onehot(input logic [1:0] idx);
        onehot = 4'b0001 << idx;
    endfunction

    // Returns {found, index} of the first set request at or after the pointer, wrapping mod 4.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic       found;
        logic [1:0] sel;
        logic [1:0] idx;
        found = 1'b0;
        sel   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = p + 2'(i);
            if (!found && r[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
        rr_pick = {found, sel};
    endfunction

    assign pick = rr_pick(req, ptr);

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        pcnt_nx   = pcnt;
        ucnt_nx   = ucnt;
        nlat_nx   = nlat;
        grant_nx  = grant;
        done_nx   = 4'b0000;
        cur_id_nx = cur_id;
        busy_nx   = busy;
        case (state)
            IDLE: begin
                if (pick[2]) begin
                    nlat_nx   = nus[pick[1:0]*W +: W];
                    cur_id_nx = pick[1:0];
                    pcnt_nx   = 16'd0;
                    ucnt_nx   = {W{1'b0}};
                    grant_nx  = onehot(pick[1:0]);
                    busy_nx   = 1'b1;
                    state_nx  = RUN;
                end else begin
                    grant_nx  = 4'b0000;
                    busy_nx   = 1'b0;
                end
            end
            RUN: begin
                // Expiry is checked before abort so a same-cycle drop still gets its done pulse.
                if (ucnt == nlat) begin
                    done_nx  = onehot(cur_id);
                    state_nx = DONE;
                end else if (!req[cur_id]) begin
                    grant_nx = 4'b0000;
                    busy_nx  = 1'b0;
                    ptr_nx   = cur_id + 2'd1;
                    state_nx = IDLE;
                end else if (pcnt == PCNT_LAST) begin
                    pcnt_nx  = 16'd0;
                    ucnt_nx  = ucnt + W'(1);
                end else begin
                    pcnt_nx  = pcnt + 16'd1;
                end
            end
            DONE: begin
                grant_nx = 4'b0000;
                busy_nx  = 1'b0;
                ptr_nx   = cur_id + 2'd1;
                state_nx = IDLE;
            end
            default: begin
                grant_nx = 4'b0000;
                busy_nx  = 1'b0;
                state_nx = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            pcnt   <= 16'd0;
            ucnt   <= {W{1'b0}};
            nlat   <= {W{1'b0}};
            grant  <= 4'b0000;
            done   <= 4'b0000;
            cur_id <= 2'd0;
            busy   <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            pcnt   <= pcnt_nx;
            ucnt   <= ucnt_nx;
            nlat   <= nlat_nx;
            grant  <= grant_nx;
            done   <= done_nx;
            cur_id <= cur_id_nx;
            busy   <= busy_nx;
        end
    end

endmodule
